// File: rtl/im2col_pkg.sv
// Shared types for the im2col window generator: FSM states, the latched frame
// configuration and the helpers that judge and step it.
package im2col_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int STRIDE_MIN = 1;
    localparam int STRIDE_MAX = 3;

    // Fields are wider than any legal image so oversized requests can be judged.
    typedef struct packed {
        logic [15:0] img_w;
        logic [15:0] img_h;
        logic [1:0]  stride;
    } cfg_t;

    function automatic logic cfg_legal(input cfg_t cfg, input int k,
                                       input int max_w, input int max_h);
        return (int'(cfg.img_w) >= k) && (int'(cfg.img_w) <= max_w) &&
               (int'(cfg.img_h) >= k) && (int'(cfg.img_h) <= max_h) &&
               (int'(cfg.stride) >= STRIDE_MIN) && (int'(cfg.stride) <= STRIDE_MAX);
    endfunction

    function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic [1:0] stride);
        return (ph == stride - 2'd1) ? 2'd0 : ph + 2'd1;
    endfunction

endpackage

// File: rtl/im2col_window_gen_if.sv
// Pixel-in / window-out handshake bundle; master is the stream source/sink,
// slave is the window generator.
interface im2col_window_gen_if #(
    parameter int DATA_W    = 16,
    parameter int MAX_IMG_W = 28,
    parameter int MAX_IMG_H = 28,
    parameter int K         = 5
);
    localparam int ROW_W = $clog2(MAX_IMG_H);
    localparam int COL_W = $clog2(MAX_IMG_W);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_win [K*K];
    logic [ROW_W-1:0]  out_row;
    logic [COL_W-1:0]  out_col;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_win, out_row, out_col, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_win, out_row, out_col, out_valid
    );
endinterface

// File: rtl/im2col_line_buf.sv
// One image row of delay: addressed by column, so each read returns the pixel
// written at the same column one row earlier, whatever the frame width.
module im2col_line_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 28,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];
endmodule

// File: rtl/im2col_window_gen.sv
// Streams a raster image and emits every strided KxK window with its top-left
// coordinate, using K-1 row buffers and a shifting KxK register window.
module im2col_window_gen
    import im2col_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int MAX_IMG_W = 28,
    parameter int MAX_IMG_H = 28,
    parameter int K         = 5
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           start,
    input  logic [$clog2(MAX_IMG_W+1)-1:0] cfg_img_w,
    input  logic [$clog2(MAX_IMG_H+1)-1:0] cfg_img_h,
    input  logic [1:0]                     cfg_stride,
    im2col_window_gen_if.slave             bus,
    output logic                           busy,
    output logic                           done,
    output logic                           cfg_err
);
    localparam int ROW_W = $clog2(MAX_IMG_H);
    localparam int COL_W = $clog2(MAX_IMG_W);
    localparam logic [15:0]      KM1     = 16'(K - 1);
    localparam logic [ROW_W-1:0] ROW_KM1 = ROW_W'(K - 1);
    localparam logic [COL_W-1:0] COL_KM1 = COL_W'(K - 1);

    state_t            state_q, state_d;
    cfg_t              cfg_q, cfg_in;
    logic              cfg_ok;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [1:0]        col_ph_q, row_ph_q;
    logic              accept, last_col, last_row, complete;
    logic [DATA_W-1:0] lb_rd   [K-1];
    logic [DATA_W-1:0] col_vec [K];
    logic [DATA_W-1:0] win_q   [K*K];
    logic [DATA_W-1:0] win_d   [K*K];

    assign cfg_in = '{img_w: 16'(cfg_img_w), img_h: 16'(cfg_img_h), stride: cfg_stride};
    assign cfg_ok = cfg_legal(cfg_in, K, MAX_IMG_W, MAX_IMG_H);

    assign bus.in_ready = (state_q == ST_RUN) && (!bus.out_valid || bus.out_ready);
    assign accept   = bus.in_valid && bus.in_ready;
    assign last_col = (16'(col_q) == cfg_q.img_w - 16'd1);
    assign last_row = (16'(row_q) == cfg_q.img_h - 16'd1);

    // Phases hold (pos-K+1) mod stride, so zero marks a window-aligned row/column.
    assign complete = accept && (16'(row_q) >= KM1) && (16'(col_q) >= KM1) &&
                      (row_ph_q == 2'd0) && (col_ph_q == 2'd0);

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = cfg_ok ? ST_RUN : ST_DONE;
            ST_RUN:   if (accept && last_col && last_row) state_d = ST_DRAIN;
            ST_DRAIN: if (!bus.out_valid) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cfg_q    <= '0;
            cfg_err  <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            col_ph_q <= '0;
            row_ph_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            cfg_q    <= cfg_in;
            cfg_err  <= !cfg_ok;
            col_q    <= '0;
            row_q    <= '0;
            col_ph_q <= '0;
            row_ph_q <= '0;
        end else if (accept) begin
            if (last_col) begin
                col_q    <= '0;
                col_ph_q <= '0;
                row_q    <= last_row ? '0 : row_q + ROW_W'(1);
                row_ph_q <= (16'(row_q) < KM1) ? 2'd0 : next_phase(row_ph_q, cfg_q.stride);
            end else begin
                col_q    <= col_q + COL_W'(1);
                col_ph_q <= (16'(col_q) < KM1) ? 2'd0 : next_phase(col_ph_q, cfg_q.stride);
            end
        end
    end

    // Buffer 0 holds the previous row; each later buffer takes its predecessor's old value.
    for (genvar i = 0; i < K - 1; i++) begin : g_lb
        if (i == 0) begin : g_first
            im2col_line_buf #(.DATA_W(DATA_W), .DEPTH(MAX_IMG_W)) u_lb (
                .clk     (clk),
                .wr_en   (accept),
                .addr    (col_q),
                .wr_data (bus.in_data),
                .rd_data (lb_rd[i])
            );
        end else begin : g_rest
            im2col_line_buf #(.DATA_W(DATA_W), .DEPTH(MAX_IMG_W)) u_lb (
                .clk     (clk),
                .wr_en   (accept),
                .addr    (col_q),
                .wr_data (lb_rd[i-1]),
                .rd_data (lb_rd[i])
            );
        end
        assign col_vec[K-2-i] = lb_rd[i];
    end
    assign col_vec[K-1] = bus.in_data;

    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[r*K+c] = win_q[r*K+c+1];
            end
            win_d[r*K+K-1] = col_vec[r];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bus.out_valid <= 1'b0;
            bus.out_row   <= '0;
            bus.out_col   <= '0;
            for (int i = 0; i < K*K; i++) begin
                win_q[i]       <= '0;
                bus.out_win[i] <= '0;
            end
        end else begin
            if (accept) begin
                for (int i = 0; i < K*K; i++) begin
                    win_q[i] <= win_d[i];
                end
            end
            if (complete) begin
                bus.out_valid <= 1'b1;
                bus.out_row   <= row_q - ROW_KM1;
                bus.out_col   <= col_q - COL_KM1;
                for (int i = 0; i < K*K; i++) begin
                    bus.out_win[i] <= win_d[i];
                end
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_im2col_window_gen.sv
// Self-checking bench: directed config table plus randomized frames, all
// windows compared against a whole-image reference model.
module tb_im2col_window_gen;
    localparam int DATA_W    = 16;
    localparam int MAX_IMG_W = 28;
    localparam int MAX_IMG_H = 28;
    localparam int K         = 5;
    localparam int CW_W      = $clog2(MAX_IMG_W + 1);
    localparam int CH_W      = $clog2(MAX_IMG_H + 1);
    localparam int OR_W      = $clog2(MAX_IMG_H);
    localparam int OC_W      = $clog2(MAX_IMG_W);
    localparam int BUDGET    = 20000;

    logic            clk = 1'b0;
    logic            nrst;
    logic            start;
    logic [CW_W-1:0] cfg_img_w;
    logic [CH_W-1:0] cfg_img_h;
    logic [1:0]      cfg_stride;
    logic            busy, done, cfg_err;

    im2col_window_gen_if #(.DATA_W(DATA_W), .MAX_IMG_W(MAX_IMG_W),
                           .MAX_IMG_H(MAX_IMG_H), .K(K)) bus ();

    im2col_window_gen #(.DATA_W(DATA_W), .MAX_IMG_W(MAX_IMG_W),
                        .MAX_IMG_H(MAX_IMG_H), .K(K)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .cfg_img_w  (cfg_img_w),
        .cfg_img_h  (cfg_img_h),
        .cfg_stride (cfg_stride),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int h;
        int s;
        int exp_windows;
        bit exp_err;
    } vec_t;

    vec_t vecs [10];
    int   pass_cnt  = 0;
    int   check_cnt = 0;
    int   img [MAX_IMG_H][MAX_IMG_W];
    int   exp_row_q [$];
    int   exp_col_q [$];

    task automatic checkOutput(input string name, input int act, input int req);
        check_cnt++;
        if (act == req) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    function automatic int pixAt(input int pi, input int w);
        int r, c;
        if (w <= 0) return 0;
        r = pi / w;
        c = pi % w;
        if (r < MAX_IMG_H && c < MAX_IMG_W) return img[r][c];
        return 0;
    endfunction

    // Reference: every stride-aligned top-left corner whose KxK block fits, in raster order.
    task automatic buildModel(input int w, input int h, input int s);
        exp_row_q.delete();
        exp_col_q.delete();
        for (int r0 = 0; r0 + K <= h; r0 += s) begin
            for (int c0 = 0; c0 + K <= w; c0 += s) begin
                exp_row_q.push_back(r0);
                exp_col_q.push_back(c0);
            end
        end
    endtask

    function automatic int windowErrors();
        int errs = 0;
        int r0, c0;
        if (exp_row_q.size() == 0) return 1000;
        r0 = exp_row_q[0];
        c0 = exp_col_q[0];
        for (int i = 0; i < K*K; i++) begin
            if (bus.out_win[i] !== DATA_W'(img[r0 + i/K][c0 + i%K])) errs++;
        end
        if (bus.out_row !== OR_W'(r0)) errs++;
        if (bus.out_col !== OC_W'(c0)) errs++;
        return errs;
    endfunction

    task automatic applyStimulus(input int w, input int h, input int s, input int exp_windows,
                                 input bit exp_err, input bit rand_pix, input int in_pct,
                                 input int out_pct, input int stall, input int abort_at,
                                 input bit mid_start);
        int    pi = 0, n_win = 0, n_done = 0, done_cycle = -1, stall_left = 0;
        bit    first_seen = 0, bad_hs = 0, pix_acc, win_acc, aborted = 0, ms_done = 0;
        string tag;
        tag = $sformatf("%0dx%0d/s%0d", w, h, s);
        for (int r = 0; r < MAX_IMG_H; r++)
            for (int c = 0; c < MAX_IMG_W; c++)
                img[r][c] = rand_pix ? int'($urandom_range(0, 65535)) : r*16 + c;
        exp_row_q.delete();
        exp_col_q.delete();
        if (!exp_err) buildModel(w, h, s);

        cfg_img_w     = CW_W'(w);
        cfg_img_h     = CH_W'(h);
        cfg_stride    = 2'(s);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        for (int cyc = 0; cyc < BUDGET; cyc++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_cycle < 0) done_cycle = cyc;
            end
            if (exp_err && (bus.in_ready || bus.out_valid)) bad_hs = 1;
            if (stall_left > 0) begin
                checkOutput({tag, " stall in_ready"}, int'(bus.in_ready), 0);
                checkOutput({tag, " stall hold"}, bus.out_valid ? windowErrors() : -1, 0);
                stall_left--;
            end
            pix_acc = bus.in_valid && bus.in_ready;
            win_acc = bus.out_valid && bus.out_ready;
            if (win_acc) begin
                if (exp_row_q.size() == 0) begin
                    checkOutput({tag, " extra window"}, 1, 0);
                end else begin
                    checkOutput($sformatf("%s window (%0d,%0d)", tag, exp_row_q[0], exp_col_q[0]),
                                windowErrors(), 0);
                    void'(exp_row_q.pop_front());
                    void'(exp_col_q.pop_front());
                end
                n_win++;
            end
            if (done_cycle >= 0 && cyc >= done_cycle + 3) break;

            @(posedge clk); #1;
            if (pix_acc) pi++;
            if (abort_at > 0 && pi >= abort_at) begin
                aborted = 1;
                break;
            end
            start     = 1'b0;
            cfg_img_w = CW_W'(w);
            if (mid_start && !ms_done && pi >= 10) begin
                start     = 1'b1;
                cfg_img_w = CW_W'(4);
                ms_done   = 1;
            end
            if (stall > 0 && !first_seen && bus.out_valid) begin
                first_seen = 1;
                stall_left = stall;
            end
            bus.in_valid  = (pi < w*h) && ($urandom_range(0, 99) < in_pct);
            bus.in_data   = DATA_W'(pixAt(pi, w));
            bus.out_ready = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 99) < out_pct);
        end

        if (aborted) begin
            nrst         = 1'b0;
            bus.in_valid = 1'b0;
            #2;
            checkOutput({tag, " abort out_valid"}, int'(bus.out_valid), 0);
            checkOutput({tag, " abort busy"}, int'(busy), 0);
            checkOutput({tag, " abort in_ready"}, int'(bus.in_ready), 0);
            checkOutput({tag, " abort done"}, int'(done), 0);
            @(negedge clk);
            @(negedge clk);
            nrst = 1'b1;
            @(posedge clk); #1;
            return;
        end

        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        start        = 1'b0;
        checkOutput({tag, " windows"}, n_win, exp_windows);
        checkOutput({tag, " done pulses"}, n_done, 1);
        checkOutput({tag, " cfg_err"}, int'(cfg_err), int'(exp_err));
        checkOutput({tag, " busy after done"}, int'(busy), 0);
        if (exp_err) begin
            checkOutput({tag, " illegal handshake"}, int'(bad_hs), 0);
            checkOutput({tag, " done latency ok"}, int'(done_cycle >= 0 && done_cycle <= 1), 1);
        end else begin
            checkOutput({tag, " pixels consumed"}, pi, w*h);
            checkOutput({tag, " windows missing"}, exp_row_q.size(), 0);
        end
    endtask

    initial begin
        vecs[0] = '{w: 7,  h: 7, s: 1, exp_windows: 9, exp_err: 0};
        vecs[1] = '{w: 7,  h: 7, s: 2, exp_windows: 4, exp_err: 0};
        vecs[2] = '{w: 7,  h: 7, s: 3, exp_windows: 1, exp_err: 0};
        vecs[3] = '{w: 4,  h: 7, s: 1, exp_windows: 0, exp_err: 1};
        vecs[4] = '{w: 5,  h: 5, s: 1, exp_windows: 1, exp_err: 0};
        vecs[5] = '{w: 7,  h: 4, s: 1, exp_windows: 0, exp_err: 1};
        vecs[6] = '{w: 28, h: 5, s: 3, exp_windows: 8, exp_err: 0};
        vecs[7] = '{w: 29, h: 7, s: 1, exp_windows: 0, exp_err: 1};
        vecs[8] = '{w: 6,  h: 9, s: 2, exp_windows: 3, exp_err: 0};
        vecs[9] = '{w: 7,  h: 7, s: 0, exp_windows: 0, exp_err: 1};

        nrst          = 1'b0;
        start         = 1'b0;
        cfg_img_w     = '0;
        cfg_img_h     = '0;
        cfg_stride    = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        checkOutput("reset out_valid", int'(bus.out_valid), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset cfg_err", int'(cfg_err), 0);
        checkOutput("reset in_ready", int'(bus.in_ready), 0);
        checkOutput("reset out_row", int'(bus.out_row), 0);
        checkOutput("reset out_col", int'(bus.out_col), 0);
        checkOutput("reset out_win0", int'(bus.out_win[0]), 0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed configuration table");
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].w, vecs[v].h, vecs[v].s, vecs[v].exp_windows, vecs[v].exp_err,
                          0, 100, 100, 0, 0, 0);
        end

        $display("[TB] back-pressure stall after first window");
        applyStimulus(7, 7, 1, 9, 0, 0, 100, 100, 10, 0, 0);

        $display("[TB] reset mid-frame, then clean restart");
        applyStimulus(7, 7, 1, 9, 0, 1, 100, 100, 0, 20, 0);
        applyStimulus(7, 7, 1, 9, 0, 1, 100, 100, 0, 0, 0);

        $display("[TB] start while busy is ignored");
        applyStimulus(7, 7, 1, 9, 0, 1, 100, 100, 0, 0, 1);

        $display("[TB] randomized full-size frames");
        applyStimulus(28, 28, 1, 576, 0, 1, 70, 60, 0, 0, 0);
        applyStimulus(28, 28, 2, 144, 0, 1, 60, 70, 0, 0, 0);
        applyStimulus(20, 17, 3, 30, 0, 1, 50, 50, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
